// File: rtl/instr_fetch_decode_if.sv
// Bus between the fetch/decode front end, its instruction ROM and the execute stage.
// Handshake: an instruction transfers on a cycle where out_valid and out_ready are both high;
// once out_valid is raised the dec_* fields hold steady until that transfer happens.
interface instr_fetch_decode_if;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  dec_op;
  logic [3:0]  dec_rd;
  logic [3:0]  dec_rs1;
  logic [3:0]  dec_rs2;
  logic [7:0]  dec_imm;
  logic        dec_we;
  logic        dec_imm_sel;
  logic [7:0]  dec_pc;

  modport master (
    output rom_addr,
    input  rom_data,
    output out_valid,
    input  out_ready,
    output dec_op,
    output dec_rd,
    output dec_rs1,
    output dec_rs2,
    output dec_imm,
    output dec_we,
    output dec_imm_sel,
    output dec_pc
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  out_valid,
    output out_ready,
    input  dec_op,
    input  dec_rd,
    input  dec_rs1,
    input  dec_rs2,
    input  dec_imm,
    input  dec_we,
    input  dec_imm_sel,
    input  dec_pc
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: owns the PC, registers and splits ROM words, and consumes
// loop instructions (opcode 0xF) locally, optionally parking until the next frame start.
module instr_fetch_decode #(
  parameter bit         SYNC_ON_LOOP = 1'b1,
  parameter logic [7:0] RESET_PC     = 8'd0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         frame_start,
  instr_fetch_decode_if.master         bus,
  output logic [15:0]                  loop_cnt,
  output logic [1:0]                   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RUN        = 2'd1,
    S_WAIT_FRAME = 2'd2
  } state_e;

  localparam logic [3:0] OP_LOOP = 4'hF;
  localparam logic [3:0] OP_LDI  = 4'h7;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] loop_cnt_q, loop_cnt_d;
  logic        valid_q, valid_d;
  logic [15:0] word_q;
  logic [7:0]  dec_pc_q;
  logic        we_q;
  logic        imm_sel_q;

  logic [3:0]  fetch_op;
  logic        can_issue;
  logic        load;

  assign fetch_op  = bus.rom_data[15:12];
  assign can_issue = !valid_q || bus.out_ready;

  // Next-state, PC and loop-counter logic; 'load' marks a cycle that fills the output register.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    loop_cnt_d = loop_cnt_q;
    load       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (fetch_op == OP_LOOP) begin
          pc_d       = bus.rom_data[7:0];
          loop_cnt_d = loop_cnt_q + 16'd1;
          state_d    = SYNC_ON_LOOP ? S_WAIT_FRAME : S_RUN;
        end else if (can_issue) begin
          load = 1'b1;
          pc_d = pc_q + 8'd1;
        end
      end
      S_WAIT_FRAME: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (frame_start) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The output register keeps draining whatever the FSM state is.
  always_comb begin
    valid_d = load | (valid_q & ~bus.out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      loop_cnt_q <= 16'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      loop_cnt_q <= loop_cnt_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q    <= 16'd0;
      dec_pc_q  <= 8'd0;
      we_q      <= 1'b0;
      imm_sel_q <= 1'b0;
    end else if (load) begin
      word_q    <= bus.rom_data;
      dec_pc_q  <= pc_q;
      we_q      <= (fetch_op != 4'h0) && !fetch_op[3];
      imm_sel_q <= (fetch_op == OP_LDI);
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.out_valid   = valid_q;
  assign bus.dec_op      = word_q[15:12];
  assign bus.dec_rd      = word_q[11:8];
  assign bus.dec_rs1     = word_q[7:4];
  assign bus.dec_rs2     = word_q[3:0];
  assign bus.dec_imm     = word_q[7:0];
  assign bus.dec_we      = we_q;
  assign bus.dec_imm_sel = imm_sel_q;
  assign bus.dec_pc      = dec_pc_q;
  assign loop_cnt        = loop_cnt_q;
  assign dbg_state       = state_q;

endmodule
